mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store controller, directly upstream of the load extender.
//  - Turns the M-stage access (address, store data, funct3) into a req/ready transaction on the data-memory port.
//  - Generates byte strobes and lane-replicated store data.
//  - Stalls the pipeline while the access is in flight.
//  - Returns the raw read word plus byte offset for load extension.
//  - Faults on misaligned/illegal accesses and on memory timeout.
// PARAMETERS
//  XLEN     32   datapath width; only 32 supported (4 byte lanes)
//  TIMEOUT  64   max BUSY cycles before fault; 0 = never time out
// PORTS
//  clk          in   1         single clock, rising edge
//  reset        in   1         asynchronous, active-high
//  MemReadM     in   1         M-stage load
//  MemWriteM    in   1         M-stage store
//  funct3M      in   3         access type (lb/lh/lw/lbu/lhu, sb/sh/sw)
//  ALUResultM   in   XLEN      effective byte address
//  WriteDataM   in   XLEN      store source (rs2)
//  StallM       out  1         hold F..M stages this cycle
//  MemFaultM    out  1         one-cycle pulse: misaligned/illegal/timeout
//  RD_data      out  XLEN      captured raw read word (to load extender)
//  byteAddrM    out  2         captured address[1:0] (to load extender)
//  mem_req      out  1         request valid (registered)
//  mem_we       out  1         1 = write
//  mem_addr     out  XLEN      word-aligned address ({addr[31:2],2'b00})
//  mem_wstrb    out  4         byte-lane write strobes (0 on reads)
//  mem_wdata    out  XLEN      lane-replicated store data
//  mem_ready    in   1         memory accepts/completes request this cycle
//  mem_rdata    in   XLEN      read data, valid with mem_ready on reads
// BEHAVIOUR
//  Reset:
//  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
//  - RD_data=0, byteAddrM=0, MemFaultM=0, timeout counter=0.
//  access = MemReadM|MemWriteM.
//  fault  = both high | illegal funct3 (load 011/110/111, store 1xx/011) | misaligned.
//  misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  FSM IDLE:
//  - access & fault -> MemFaultM=1 for that cycle, no request, StallM=0, stay IDLE.
//  - access & !fault -> StallM=1, register mem_* outputs, mem_req<=1, ->BUSY.
//  FSM BUSY:
//  - StallM=1; mem_* held stable while mem_req=1.
//  - mem_ready -> mem_req<=0; on read RD_data<=mem_rdata, byteAddrM<=addr[1:0]; ->DONE.
//  - timeout: counter increments each BUSY cycle without mem_ready.
//    counter==TIMEOUT-1 & !mem_ready -> mem_req<=0, MemFaultM<=1, ->DONE.
//  FSM DONE:
//  - StallM=0 (instruction leaves M at this edge); RD_data/byteAddrM valid.
//  - ->IDLE; counter cleared.
//  Latency: min 3 cycles (IDLE, BUSY w/ ready, DONE); +1 per wait cycle.
//  Store lanes (off=addr[1:0]):
//  - sb: wstrb=4'b0001<<off, wdata={4{wd[7:0]}}.
//  - sh: wstrb=off[1]?1100:0011, wdata={2{wd[15:0]}}.
//  - sw: wstrb=1111, wdata=wd.
//  Read edge cases:
//  - Reads: wstrb=0, wdata=0.
//  - RD_data holds last captured value until next read completes.
//  - Stores leave RD_data unchanged.
//  Other boundary cases:
//  - mem_ready while mem_req=0: ignored.
//  - Back-to-back accesses: IDLE re-evaluates the new instruction the cycle after DONE; no gap otherwise.
//  - Reset mid-BUSY: mem_req drops asynchronously; transaction abandoned (memory must tolerate).
// STRUCTURE
//  - Package mem_pkg: funct3 constants (F3_LB..F3_SW), state_t enum {IDLE,BUSY,DONE}, MEM_LANES=XLEN/8.
//  - Sub-module store_align (combinational): funct3, off, wd -> wstrb, wdata, misaligned, illegal.
//  - Top holds FSM, timeout counter, output registers.
// TESTING
//  - lw @0x100, mem_ready 2 cycles after req, rdata=0xDEADBEEF
//    -> StallM high 3 cycles, then RD_data=0xDEADBEEF, byteAddrM=0.
//  - sb 0xA5 @0x203 -> mem_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5, mem_we=1.
//  - sh @0x202, wd=0x1234 -> wstrb=1100, wdata=0x12341234.
//  - lh @0x101 -> MemFaultM pulse, no mem_req, StallM=0.
//  - TIMEOUT=4, mem_ready never asserted -> mem_req drops after 4 BUSY cycles, MemFaultM=1, back to IDLE.
//  - reset asserted in BUSY -> mem_req=0 same cycle, state IDLE, RD_data=0.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage load/store controller:
//   - funct3 encodings for RV32 loads and stores
//   - FSM state type for the access controller
//   - lane count of the 32-bit data-memory port
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_XLEN  = 32;
  localparam int MEM_LANES = MEM_XLEN / 8;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (share the low codes with the loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/store_align.sv
// ---------------------------------------------------------------------------
// store_align
// Combinational decode of one memory access: classifies funct3 as legal or
// illegal, detects misalignment, and for stores builds the byte strobes and
// lane-replicated write data. Loads always produce zero strobes and data.
// Ports:
//   i_funct3     access type
//   i_isStore    1 = store, 0 = load
//   i_off        byte offset (address[1:0])
//   i_wd         store source register value
//   o_wstrb      byte-lane write strobes
//   o_wdata      replicated store data
//   o_misaligned half on odd address, or word not on a 4-byte boundary
//   o_illegal    funct3 not a valid load/store encoding
// Only a 32-bit datapath (4 lanes) is supported.
// ---------------------------------------------------------------------------
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]           i_funct3,
  input  logic                 i_isStore,
  input  logic [1:0]           i_off,
  input  logic [MEM_XLEN-1:0]  i_wd,
  output logic [MEM_LANES-1:0] o_wstrb,
  output logic [MEM_XLEN-1:0]  o_wdata,
  output logic                 o_misaligned,
  output logic                 o_illegal
);

  // Size is encoded in funct3[1:0] for both loads and stores, so alignment
  // does not depend on direction. Stores only have the three low encodings;
  // loads additionally have the two unsigned variants.
  always_comb begin
    o_wstrb      = '0;
    o_wdata      = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;

    case (i_funct3[1:0])
      2'b01:   o_misaligned = i_off[0];
      2'b10:   o_misaligned = (i_off != 2'b00);
      default: o_misaligned = 1'b0;
    endcase

    if (i_isStore) begin
      o_illegal = i_funct3[2] | (i_funct3 == 3'b011);
    end else begin
      o_illegal = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) |
                  (i_funct3 == 3'b111);
    end

    if (i_isStore && !o_illegal) begin
      case (i_funct3)
        F3_SB: begin
          o_wstrb = 4'b0001 << i_off;
          o_wdata = {4{i_wd[7:0]}};
        end
        F3_SH: begin
          o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wd[15:0]}};
        end
        F3_SW: begin
          o_wstrb = 4'b1111;
          o_wdata = i_wd;
        end
        default: begin
          o_wstrb = '0;
          o_wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store controller sitting in front of the load extender.
// Turns the M-stage access into a req/ready transaction, stalls the pipeline
// while it is in flight, and returns the raw read word plus byte offset.
// Misaligned/illegal accesses fault immediately without touching memory; a
// memory that never answers faults after TIMEOUT busy cycles.
// Ports:
//   clk, reset                 clock / async active-high reset
//   MemReadM, MemWriteM        M-stage load / store
//   funct3M                    access type
//   ALUResultM                 effective byte address
//   WriteDataM                 store source
//   StallM                     hold F..M this cycle
//   MemFaultM                  one-cycle fault pulse
//   RD_data, byteAddrM         captured read word and address[1:0]
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata       registered request to data memory
//   mem_ready, mem_rdata       memory handshake / read data
// Parameters:
//   XLEN     datapath width (only 32 supported)
//   TIMEOUT  busy cycles before fault; 0 disables the timeout
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [2:0]           funct3M,
  input  logic [XLEN-1:0]      ALUResultM,
  input  logic [XLEN-1:0]      WriteDataM,
  output logic                 StallM,
  output logic                 MemFaultM,
  output logic [XLEN-1:0]      RD_data,
  output logic [1:0]           byteAddrM,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [MEM_LANES-1:0] mem_wstrb,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_ready,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                 r_state;
  state_t                 w_nextState;
  logic                   w_access;
  logic                   w_fault;
  logic                   w_misaligned;
  logic                   w_illegal;
  logic                   w_idleFault;
  logic                   w_accept;
  logic                   w_complete;
  logic                   w_timeout;
  logic [MEM_LANES-1:0]   w_wstrb;
  logic [XLEN-1:0]        w_wdata;

  logic                   r_memReq;
  logic                   r_memWe;
  logic [XLEN-1:0]        r_memAddr;
  logic [MEM_LANES-1:0]   r_memWstrb;
  logic [XLEN-1:0]        r_memWdata;
  logic [XLEN-1:0]        r_rdData;
  logic [1:0]             r_byteAddr;
  logic [1:0]             r_off;
  logic                   r_timeoutFault;
  logic [CW-1:0]          r_count;

  store_align u_storeAlign (
    .i_funct3     (funct3M),
    .i_isStore    (MemWriteM),
    .i_off        (ALUResultM[1:0]),
    .i_wd         (WriteDataM),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign w_access   = MemReadM | MemWriteM;
  assign w_fault    = (MemReadM & MemWriteM) | w_illegal | w_misaligned;
  assign w_accept   = (r_state == IDLE) & w_access & ~w_fault;
  // A ready seen without an outstanding request is not a completion.
  assign w_complete = (r_state == BUSY) & r_memReq & mem_ready;
  assign w_timeout  = (TIMEOUT != 0) && (r_state == BUSY) && !mem_ready &&
                      (r_count == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and stall. StallM drops in DONE so the instruction leaves M
  // on the DONE edge; the next instruction is evaluated in the following IDLE.
  always_comb begin
    w_nextState = r_state;
    StallM      = 1'b0;
    w_idleFault = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_fault) begin
            w_idleFault = 1'b1;
          end else begin
            StallM      = 1'b1;
            w_nextState = BUSY;
          end
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (w_complete || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request registers are loaded once on accept and held until the next
  // accept, so the memory sees stable fields for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_memReq       <= 1'b0;
      r_memWe        <= 1'b0;
      r_memAddr      <= '0;
      r_memWstrb     <= '0;
      r_memWdata     <= '0;
      r_rdData       <= '0;
      r_byteAddr     <= 2'b00;
      r_off          <= 2'b00;
      r_timeoutFault <= 1'b0;
    end else begin
      r_timeoutFault <= 1'b0;
      if (w_accept) begin
        r_memReq   <= 1'b1;
        r_memWe    <= MemWriteM;
        r_memAddr  <= {ALUResultM[XLEN-1:2], 2'b00};
        r_memWstrb <= w_wstrb;
        r_memWdata <= w_wdata;
        r_off      <= ALUResultM[1:0];
      end
      if (w_complete) begin
        r_memReq <= 1'b0;
        if (!r_memWe) begin
          r_rdData   <= mem_rdata;
          r_byteAddr <= r_off;
        end
      end
      if (w_timeout) begin
        r_memReq       <= 1'b0;
        r_timeoutFault <= 1'b1;
      end
    end
  end

  // Counts busy cycles without ready; cleared whenever not waiting in BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if ((r_state == BUSY) && !mem_ready) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  assign MemFaultM = w_idleFault | r_timeoutFault;
  assign RD_data   = r_rdData;
  assign byteAddrM = r_byteAddr;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wstrb = r_memWstrb;
  assign mem_wdata = r_memWdata;

endmodule
